// File: rtl/rx_pkg.sv
// Shared widths and FIFO entry layout for the UART receive word packer.
package rx_pkg;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef logic [2:0] byte_cnt_t;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        byte_cnt_t         bytes;
    } fifo_entry_t;
endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with registered full/valid flags and an exact level count.
module word_fifo
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fifo_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   i_push,
    input  entry_t                 i_entry,
    input  logic                   i_pop,
    output entry_t                 o_entry,
    output logic                   o_full,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               valid_q, valid_d;
    logic               do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_push  = clk_en && i_push && !full_q;
        do_pop   = clk_en && i_pop && valid_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = i_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LVL_W'(DEPTH));
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    assign o_entry = mem_q[rd_ptr_q];
    assign o_full  = full_q;
    assign o_valid = valid_q;
    assign o_level = level_q;
endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes into little-endian 32-bit words with flush/idle-timeout push.
// Optional running XOR checksum enabled by defining RX_CHECKSUM_EN.
module uart_word_packer
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic                   o_in_ready,
    output logic [31:0]            o_word,
    output logic [2:0]             o_word_bytes,
    output logic                   o_word_valid,
    input  logic                   i_word_ready,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [7:0]             o_checksum,
    input  logic                   i_checksum_clr
);
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [WORD_W-1:0] asm_q, asm_d;
    byte_cnt_t         idx_q, idx_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              run_q, run_d;

    logic              fifo_full;
    logic              accept;
    logic              push;
    logic              idle_hit;
    logic [WORD_W-1:0] lane_word;
    fifo_entry_t       push_entry;
    fifo_entry_t       head_entry;

    assign o_in_ready = run_q && !(fifo_full && ((idx_q == byte_cnt_t'(3)) || i_flush));
    assign accept     = clk_en && i_valid && o_in_ready;
    assign idle_hit   = (TIMEOUT_CYCLES != 0) && (idle_q == IDLE_MAX);

    always_comb begin
        asm_d     = asm_q;
        idx_d     = idx_q;
        idle_d    = idle_q;
        run_d     = run_q;
        push      = 1'b0;
        lane_word = asm_q;

        if (accept) begin
            lane_word[{idx_q[1:0], 3'b000} +: BYTE_W] = i_data;
        end
        push_entry.word  = lane_word;
        push_entry.bytes = idx_q + byte_cnt_t'(accept);

        if (clk_en) begin
            run_d = 1'b1;
            // Flush > complete > timeout; all share the same assembled word.
            if (i_flush && !fifo_full && (idx_q != '0 || accept)) begin
                push = 1'b1;
            end else if (accept && idx_q == byte_cnt_t'(3)) begin
                push = 1'b1;
            end else if (idle_hit && idx_q != '0 && !accept && !fifo_full) begin
                push = 1'b1;
            end

            if (push) begin
                asm_d = '0;
                idx_d = '0;
            end else if (accept) begin
                asm_d = lane_word;
                idx_d = idx_q + byte_cnt_t'(1);
            end

            // Saturates at the threshold so a blocked timeout push fires once space frees.
            if (accept || push) begin
                idle_d = '0;
            end else if (TIMEOUT_CYCLES != 0 && idx_q != '0 && !idle_hit) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q  <= '0;
            idx_q  <= '0;
            idle_q <= '0;
            run_q  <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            idx_q  <= idx_d;
            idle_q <= idle_d;
            run_q  <= run_d;
        end
    end

    word_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .i_push  (push),
        .i_entry (push_entry),
        .i_pop   (i_word_ready),
        .o_entry (head_entry),
        .o_full  (fifo_full),
        .o_valid (o_word_valid),
        .o_level (o_level)
    );

    assign o_word       = head_entry.word;
    assign o_word_bytes = head_entry.bytes;

`ifdef RX_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (clk_en) begin
            if (i_checksum_clr) begin
                chk_d = '0;
            end
            if (accept) begin
                chk_d = chk_d ^ i_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign o_checksum = chk_q;
`else
    logic unused_chk_clr;
    assign unused_chk_clr = i_checksum_clr;
    assign o_checksum     = '0;
`endif
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed self-checking bench for uart_word_packer (DEPTH=4, TIMEOUT_CYCLES=8).
module tb_uart_word_packer;
`ifdef RX_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_in_ready;
    logic [31:0] o_word;
    logic [2:0]  o_word_bytes;
    logic        o_word_valid;
    logic        i_word_ready;
    logic        i_flush;
    logic [2:0]  o_level;
    logic [7:0]  o_checksum;
    logic        i_checksum_clr;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    uart_word_packer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_in_ready     (o_in_ready),
        .o_word         (o_word),
        .o_word_bytes   (o_word_bytes),
        .o_word_valid   (o_word_valid),
        .i_word_ready   (i_word_ready),
        .i_flush        (i_flush),
        .o_level        (o_level),
        .o_checksum     (o_checksum),
        .i_checksum_clr (i_checksum_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (!o_in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!o_in_ready) check("send_wait", {31'd0, o_in_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [31:0] exp_word, input logic [2:0] exp_bytes);
        check({tag, "_valid"}, {31'd0, o_word_valid}, 32'd1);
        if (o_word_valid) begin
            check({tag, "_word"}, o_word, exp_word);
            check({tag, "_bytes"}, {29'd0, o_word_bytes}, {29'd0, exp_bytes});
        end
        i_word_ready = 1'b1;
        tick();
        i_word_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; i_data = '0; i_valid = 1'b0;
        i_word_ready = 1'b0; i_flush = 1'b0; i_checksum_clr = 1'b0;

        // reset state
        tick(); tick();
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("rst_valid", {31'd0, o_word_valid}, 32'd0);
        check("rst_level", {29'd0, o_level}, 32'd0);
        check("rst_word", o_word, 32'd0);
        check("rst_chk", {24'd0, o_checksum}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, o_in_ready}, 32'd1);
        check("post_rst_level", {29'd0, o_level}, 32'd0);

        // basic word, consumer ready
        i_word_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("basic_early", {31'd0, o_word_valid}, 32'd0);
        send_byte(8'h44);
        check("basic_valid", {31'd0, o_word_valid}, 32'd1);
        check("basic_word", o_word, 32'h4433_2211);
        check("basic_bytes", {29'd0, o_word_bytes}, 32'd4);
        tick();
        check("basic_popped", {31'd0, o_word_valid}, 32'd0);
        i_word_ready = 1'b0;

        // backpressure: fill the FIFO, stall at byte_idx 3
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1));
        check("bp_level_full", {29'd0, o_level}, 32'd4);
        check("bp_ready_idx0", {31'd0, o_in_ready}, 32'd1);
        send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
        check("bp_ready_drop", {31'd0, o_in_ready}, 32'd0);
        check("bp_head", o_word, 32'h0403_0201);
        i_data = 8'h14; i_valid = 1'b1; i_word_ready = 1'b1;
        tick();
        i_word_ready = 1'b0;
        check("bp_level_after_pop", {29'd0, o_level}, 32'd3);
        check("bp_ready_rise", {31'd0, o_in_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        check("bp_level_refill", {29'd0, o_level}, 32'd4);
        pop_word("bp_w1", 32'h0807_0605, 3'd4);
        pop_word("bp_w2", 32'h0C0B_0A09, 3'd4);
        pop_word("bp_w3", 32'h100F_0E0D, 3'd4);
        pop_word("bp_w4", 32'h1413_1211, 3'd4);
        check("bp_drained", {29'd0, o_level}, 32'd0);

        // idle timeout
        send_byte(8'hAA); send_byte(8'hBB);
        for (int i = 0; i < 8; i++) tick();
        check("to_no_early_push", {31'd0, o_word_valid}, 32'd0);
        tick();
        pop_word("to_word", 32'h0000_BBAA, 3'd2);

        // flush with accept at byte_idx 0, then empty flush, then partial flush
        i_data = 8'hCC; i_valid = 1'b1; i_flush = 1'b1;
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        check("fl_level", {29'd0, o_level}, 32'd1);
        pop_word("fl_cc", 32'h0000_00CC, 3'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("fl_noop_level", {29'd0, o_level}, 32'd0);
        send_byte(8'hDD); send_byte(8'hEE);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        pop_word("fl_partial", 32'h0000_EEDD, 3'd2);

        // reset mid-word with two words queued, then clk_en gating
        for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i));
        check("mr_level", {29'd0, o_level}, 32'd2);
        rst_n = 1'b0;
        tick();
        check("mr_level_rst", {29'd0, o_level}, 32'd0);
        check("mr_valid_rst", {31'd0, o_word_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        clk_en = 1'b0; i_data = 8'h77; i_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_valid = 1'b0; clk_en = 1'b1;
        check("ce_level", {29'd0, o_level}, 32'd0);
        send_byte(8'h5A);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        pop_word("mr_lane0", 32'h0000_005A, 3'd1);

        // checksum
        i_checksum_clr = 1'b1;
        tick();
        i_checksum_clr = 1'b0;
        check("ck_clr", {24'd0, o_checksum}, 32'd0);
        send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h55);
        check("ck_xor", {24'd0, o_checksum}, CHK_EN ? 32'h0000_00AA : 32'd0);
        i_checksum_clr = 1'b1;
        send_byte(8'h01);
        i_checksum_clr = 1'b0;
        check("ck_clr_accept", {24'd0, o_checksum}, CHK_EN ? 32'h0000_0001 : 32'd0);
        pop_word("ck_word", 32'h0155_F00F, 3'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Sits between the UART receive AXI-stream output and the boot loader's byte input.
- Packs received bytes into little-endian 32-bit words and buffers them in a small FIFO.
- Presents words to the boot loader over a valid/ready handshake, so the loader writes RAM one word per handshake instead of one byte per handshake.
- Flushes partial words on request or after an idle timeout, so a trailing image of 1-3 bytes is delivered.

Parameters:
- DEPTH, 4, number of FIFO word entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, number of idle clk_en cycles after which a partial word is auto-flushed; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  qualifies every state update; when low, all state holds and no handshake completes.
- i_data  in  8  byte from the UART receiver.
- i_valid  in  1  i_data is valid.
- o_in_ready  out  1  the packer accepts i_data this cycle.
- o_word  out  32  FIFO head word; the first-received byte is in [7:0].
- o_word_bytes  out  3  valid bytes in o_word, range 1-4.
- o_word_valid  out  1  FIFO is not empty.
- i_word_ready  in  1  consumer pops the FIFO head.
- i_flush  in  1  push the current partial word now.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_checksum  out  8  running XOR of accepted bytes (RX_CHECKSUM_EN only).
- i_checksum_clr  in  1  clears o_checksum (RX_CHECKSUM_EN only).

Behaviour:
- Reset:
  - While rst_n is low, all registers and outputs are 0, including o_in_ready.
  - After release, the FIFO is empty, byte_idx is 0 and o_in_ready is 1.
- Byte accept:
  - A byte is accepted when clk_en && i_valid && o_in_ready.
  - The byte is written to lane byte_idx of the assembly register, and byte_idx increments.
- Push conditions (each pushes one word to the FIFO and returns byte_idx to 0):
  - Complete: a byte is accepted while byte_idx==3; bytes=4.
  - Flush: i_flush is high and (byte_idx>0 or a byte is accepted); bytes = byte_idx plus the accepted byte, if any.
  - Timeout: byte_idx>0, no byte accepted, and the idle counter equals TIMEOUT_CYCLES; bytes=byte_idx.
- Padding and idle counter:
  - Unwritten lanes of a pushed word are 0.
  - The idle counter clears on any accept or push.
  - The idle counter increments on each clk_en cycle while byte_idx>0.
- Backpressure:
  - Full is the registered FIFO-full flag; a pop in the same cycle does not unblock a push.
  - o_in_ready = !(full && (byte_idx==3 || i_flush)).
  - A timeout that fires while the FIFO is full waits; the counter saturates and the push happens on the first non-full cycle.
  - i_flush with byte_idx==0 and no accept is a no-op.
  - Priority when several push conditions coincide: flush > complete > timeout. Only one push occurs per cycle.
- FIFO:
  - First-word-fall-through.
  - Latency: push on cycle N gives o_word_valid on cycle N+1 when the FIFO was empty.
  - Pop happens when clk_en && o_word_valid && i_word_ready.
  - Push and pop in the same cycle (when not full) leave o_level unchanged.
  - Pointers wrap modulo DEPTH; o_level is exact, from 0 to DEPTH.
  - o_word and o_word_bytes are don't-care when o_word_valid is 0; the bench must not check them then.
- Words are never dropped or reordered; there is no overrun path inside the block.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - o_checksum ^= i_data on every accepted byte.
  - i_checksum_clr sets it to 0. If a clear and an accept coincide, o_checksum = i_data.
  - Reset value is 0.
- Undefined: o_checksum is tied to 0 and i_checksum_clr is ignored. Both ports remain present.

Decomposition:
- Package rx_pkg:
  - BYTE_W=8, WORD_W=32.
  - typedef byte_cnt_t (3 bits).
  - typedef fifo_entry_t (packed struct: word, bytes).
- Sub-module word_fifo, parameterised on DEPTH and the entry type:
  - Registered full/empty flags.
  - FWFT output.
  - Async active-low reset.
  - clk_en qualification.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 with consumer ready -> one word 0x44332211, bytes=4, o_word_valid one cycle after the 4th accept.
- i_word_ready=0, DEPTH=4, 16 bytes -> o_level reaches 4 and o_in_ready drops when byte_idx==3; pop one word -> o_in_ready rises next cycle and the 17th-20th bytes land in order.
- Bytes 0xAA,0xBB, then idle for TIMEOUT_CYCLES=8 -> word 0x0000BBAA, bytes=2; no push before the 8th idle cycle.
- i_flush together with the accept of 0xCC at byte_idx=0 -> word 0x000000CC, bytes=1 the same cycle; i_flush with byte_idx=0 and no byte -> o_level unchanged.
- rst_n low mid-word (byte_idx=2) with 2 words queued -> o_level=0, o_word_valid=0, next bytes start at lane 0; clk_en=0 for 5 cycles with i_valid=1 -> nothing accepted.
- RX_CHECKSUM_EN, bytes 0x0F,0xF0,0x55 -> o_checksum=0xAA; clear together with an accept of 0x01 -> 0x01.
